uart_rx_deser_multi: RTL and testbench
======================================

// Module: uart_rx_deser_multi
// PURPOSE
//   Parametrised UART RX deserializer. Samples the raw RX line at the bit centre using the
//   edge counter driven by the RX edge/bit counter. Assembles 5..DATA_WIDTH data bits,
//   runtime-selectable, in LSB-first or MSB-first order. Presents the word to the
//   parity/stop checkers through a shadow register and a one-cycle valid strobe.
//   Sits between the RX FSM (which drives deser_en) and the parity check / RX output stage.
// PARAMETERS
//   DATA_WIDTH      9   maximum data bits per frame; p_data width
//   PRESCALE_WIDTH  6   width of prescale and edge_cnt
//   LEN_WIDTH       4   width of data_len; must hold DATA_WIDTH
// PORTS
//   clk         in   1               system clock (oversampling clock)
//   reset       in   1               asynchronous reset, active-high
//   deser_en    in   1               frame window from RX FSM; high for the data bits
//   rx_in       in   1               raw serial RX line (already synchronised)
//   prescale    in   PRESCALE_WIDTH  oversampling ratio (4..2^PRESCALE_WIDTH-1)
//   edge_cnt    in   PRESCALE_WIDTH  position within current bit, 0..prescale-1
//   data_len    in   LEN_WIDTH       data bits per frame; latched at frame start
//   msb_first   in   1               1 = first received bit is MSB; latched at frame start
//   p_data      out  DATA_WIDTH      last completed word, right-aligned, unused MSBs = 0
//   data_valid  out  1               one-cycle pulse: p_data updated this cycle
//   busy        out  1               high in SHIFT state
//   noise_err   out  1               sampling disagreement seen in last word (see CONFIG)
// BEHAVIOUR
//   Reset: state=IDLE, p_data=0, data_valid=0, busy=0, noise_err=0, shift reg and bit count=0.
//   Centre point mid = prescale>>1. The sample event fires on the cycle where edge_cnt==mid.
//   FSM states:
//   - IDLE:  deser_en=1 -> SHIFT. Latch len = clamp(data_len, 5, DATA_WIDTH) and msb_first.
//            Clear the shift reg, bit_cnt and the noise flag.
//   - SHIFT: on each sample event, capture the bit and bit_cnt++.
//            LSB-first: sreg[bit_cnt] = bit.
//            MSB-first: sreg = {sreg[DATA_WIDTH-2:0], bit}.
//            Both orders yield a right-aligned len-bit word.
//            On the clock edge that captures bit len-1:
//              p_data <= word with bits >= len forced 0; data_valid <= 1 for one cycle;
//              noise_err <= frame flag; go to DONE.
//            If deser_en=0 in SHIFT before the last bit: abort to IDLE. No data_valid.
//            p_data and noise_err keep their previous values.
//   - DONE:  ignore samples. deser_en=0 -> IDLE. This stops re-arming while the FSM holds
//            deser_en high through parity/stop.
//   p_data changes only with data_valid. data_len and msb_first changes mid-frame are ignored.
//   busy is high only in SHIFT.
//   If deser_en=0 and the sample event fall on the same cycle, the abort wins.
//   Async reset mid-frame returns everything to its reset values immediately.
// CONFIGURATION
//   UART_RX_MAJORITY_EN defined:
//     - Sample rx_in at edge_cnt = mid-1, mid and mid+1; the captured bit is the 2-of-3
//       majority, committed at mid+1. The commit replaces the sample event for bit capture
//       and completion.
//     - Any disagreement among the three sets the frame noise flag, reported on noise_err
//       with data_valid.
//     - Requires prescale >= 4.
//   Not defined:
//     - Single sample at edge_cnt == mid. noise_err is tied to 0.
// TESTING
//   1 prescale=8, len=8, LSB-first, line bits 1,0,1,0,0,1,0,1 -> p_data=0x0A5,
//     data_valid exactly 1 cycle, busy low after.
//   2 len=8, msb_first=1, line bits 1,0,0,0,0,0,0,0 -> p_data=0x080.
//     Same bits with LSB-first -> 0x001.
//   3 data_len=5, LSB-first, bits 1,1,0,1,0 -> p_data=0x00B.
//     data_len=12 clamps to 9: bits 1 x9 -> 0x1FF. data_len=2 clamps to 5.
//   4 after 0x0A5, drop deser_en after 3 bits -> no data_valid, p_data stays 0x0A5.
//     Next full frame 0x03C -> p_data=0x03C.
//   5 MAJORITY_EN, prescale=8: flip rx_in only at edge_cnt=4 of bit 0 of 0x0A5
//     -> p_data=0x0A5, noise_err=1. Without the macro -> p_data=0x0A4, noise_err=0.
//   6 assert reset at bit 4 -> p_data=0, data_valid=0, busy=0 immediately.
//     Hold deser_en high through DONE -> no second data_valid until deser_en toggles.

Source files
------------

// File: rtl/uart_rx_deser_multi.sv
// UART RX deserializer: centre-samples rx_in, assembles 5..DATA_WIDTH bits LSB- or MSB-first.
// Optional 3-sample majority voting with noise flag when UART_RX_MAJORITY_EN is defined.
module uart_rx_deser_multi #(
  parameter int unsigned DATA_WIDTH     = 9,
  parameter int unsigned PRESCALE_WIDTH = 6,
  parameter int unsigned LEN_WIDTH      = 4
) (
  input  logic                      i_clk,
  input  logic                      i_reset,
  input  logic                      i_deser_en,
  input  logic                      i_rx_in,
  input  logic [PRESCALE_WIDTH-1:0] i_prescale,
  input  logic [PRESCALE_WIDTH-1:0] i_edge_cnt,
  input  logic [LEN_WIDTH-1:0]      i_data_len,
  input  logic                      i_msb_first,
  output logic [DATA_WIDTH-1:0]     o_p_data,
  output logic                      o_data_valid,
  output logic                      o_busy,
  output logic                      o_noise_err
);

  localparam int unsigned MIN_LEN = 5;

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

  state_t                    r_state;
  logic [DATA_WIDTH-1:0]     r_sreg;
  logic [LEN_WIDTH-1:0]      r_bit_cnt;
  logic [LEN_WIDTH-1:0]      r_len;
  logic                      r_msb;
  logic                      r_noise;
  logic [DATA_WIDTH-1:0]     r_p_data;
  logic                      r_data_valid;
  logic                      r_busy;
  logic                      r_noise_err;

  logic [PRESCALE_WIDTH-1:0] w_mid;
  logic                      w_commit;
  logic                      w_bit;
  logic                      w_dis;
  logic [LEN_WIDTH-1:0]      w_len_clamp;
  logic [DATA_WIDTH-1:0]     w_sreg_next;
  logic [DATA_WIDTH-1:0]     w_mask;

  assign w_mid = i_prescale >> 1;

`ifdef UART_RX_MAJORITY_EN
  // Early samples at mid-1 and mid; the vote commits with the live sample at mid+1.
  logic r_s_lo;
  logic r_s_mid;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_s_lo  <= 1'b0;
      r_s_mid <= 1'b0;
    end else begin
      if (i_edge_cnt == PRESCALE_WIDTH'(w_mid - PRESCALE_WIDTH'(1))) r_s_lo <= i_rx_in;
      if (i_edge_cnt == w_mid) r_s_mid <= i_rx_in;
    end
  end

  assign w_commit = (i_edge_cnt == PRESCALE_WIDTH'(w_mid + PRESCALE_WIDTH'(1)));
  assign w_bit    = (r_s_lo & r_s_mid) | (r_s_lo & i_rx_in) | (r_s_mid & i_rx_in);
  assign w_dis    = !((r_s_lo == r_s_mid) && (r_s_mid == i_rx_in));
`else
  assign w_commit = (i_edge_cnt == w_mid);
  assign w_bit    = i_rx_in;
  assign w_dis    = 1'b0;
`endif

  always_comb begin
    w_len_clamp = i_data_len;
    if (i_data_len < LEN_WIDTH'(MIN_LEN))         w_len_clamp = LEN_WIDTH'(MIN_LEN);
    else if (i_data_len > LEN_WIDTH'(DATA_WIDTH)) w_len_clamp = LEN_WIDTH'(DATA_WIDTH);
  end

  // Both orders leave the word right-aligned in the low len bits.
  always_comb begin
    w_sreg_next = r_sreg;
    if (r_msb) w_sreg_next = {r_sreg[DATA_WIDTH-2:0], w_bit};
    else       w_sreg_next[r_bit_cnt] = w_bit;
  end

  always_comb begin
    w_mask = '0;
    for (int i = 0; i < int'(DATA_WIDTH); i++) w_mask[i] = (LEN_WIDTH'(i) < r_len);
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state      <= S_IDLE;
      r_sreg       <= '0;
      r_bit_cnt    <= '0;
      r_len        <= LEN_WIDTH'(MIN_LEN);
      r_msb        <= 1'b0;
      r_noise      <= 1'b0;
      r_p_data     <= '0;
      r_data_valid <= 1'b0;
      r_busy       <= 1'b0;
      r_noise_err  <= 1'b0;
    end else begin
      r_data_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_deser_en) begin
            r_state   <= S_SHIFT;
            r_len     <= w_len_clamp;
            r_msb     <= i_msb_first;
            r_sreg    <= '0;
            r_bit_cnt <= '0;
            r_noise   <= 1'b0;
            r_busy    <= 1'b1;
          end
        end
        S_SHIFT: begin
          // Abort has priority over a coincident sample.
          if (!i_deser_en) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end else if (w_commit) begin
            r_sreg    <= w_sreg_next;
            r_bit_cnt <= r_bit_cnt + LEN_WIDTH'(1);
            r_noise   <= r_noise | w_dis;
            if (r_bit_cnt == r_len - LEN_WIDTH'(1)) begin
              r_p_data     <= w_sreg_next & w_mask;
              r_data_valid <= 1'b1;
              r_noise_err  <= r_noise | w_dis;
              r_state      <= S_DONE;
              r_busy       <= 1'b0;
            end
          end
        end
        S_DONE: begin
          if (!i_deser_en) r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign o_p_data     = r_p_data;
  assign o_data_valid = r_data_valid;
  assign o_busy       = r_busy;
  assign o_noise_err  = r_noise_err;

endmodule

// File: tb/tb_uart_rx_deser_multi.sv
// Scoreboard bench for uart_rx_deser_multi: directed frames, expected words queued at issue,
// popped by a monitor on each data_valid. Honours UART_RX_MAJORITY_EN like the design.
module tb_uart_rx_deser_multi;

  logic       clk = 1'b0;
  logic       reset;
  logic       deser_en;
  logic       rx_in;
  logic [5:0] prescale;
  logic [5:0] edge_cnt;
  logic [3:0] data_len;
  logic       msb_first;
  logic [8:0] p_data;
  logic       data_valid;
  logic       busy;
  logic       noise_err;

  int n_vec = 0;
  int n_err = 0;
  logic [9:0] exp_q[$];
  logic prev_valid = 1'b0;

  uart_rx_deser_multi dut (
    .i_clk(clk), .i_reset(reset), .i_deser_en(deser_en), .i_rx_in(rx_in),
    .i_prescale(prescale), .i_edge_cnt(edge_cnt), .i_data_len(data_len),
    .i_msb_first(msb_first), .o_p_data(p_data), .o_data_valid(data_valid),
    .o_busy(busy), .o_noise_err(noise_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pop expected {noise, data} on every valid strobe.
  always @(posedge clk) begin
    #2;
    if (data_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_valid", 16'(p_data), 16'h0);
        n_vec++; n_err++;
        $display("FAIL spurious_valid: data_valid with empty scoreboard, p_data=0x%0h", p_data);
      end else begin
        logic [9:0] e;
        e = exp_q.pop_front();
        chk("p_data", 16'(p_data), 16'(e[8:0]));
        chk("noise_err", 16'(noise_err), 16'(e[9]));
      end
      chk("valid_one_cycle", 16'(prev_valid), 16'h0);
    end
    prev_valid = data_valid;
  end

  // Drive one frame at prescale 8; stop_at >= 0 aborts (or resets) before that bit.
  task automatic frame(input logic [15:0] bits, input int nbits, input logic [3:0] len,
                       input logic msb, input int flip_bit, input int stop_at,
                       input bit do_reset);
    bit stopped = 1'b0;
    for (int b = 0; b < nbits && !stopped; b++) begin
      for (int e = 0; e < 8 && !stopped; e++) begin
        @(negedge clk);
        if (b == stop_at && e == 2) begin
          if (do_reset) begin
            reset = 1'b1;
            #1;
            chk("rst_p_data", 16'(p_data), 16'h0);
            chk("rst_valid", 16'(data_valid), 16'h0);
            chk("rst_busy", 16'(busy), 16'h0);
            @(negedge clk);
            reset = 1'b0;
          end
          deser_en = 1'b0;
          stopped  = 1'b1;
        end else begin
          if (b == 0 && e == 0) begin
            data_len  = len;
            msb_first = msb;
          end else if (b == 1 && e == 0) begin
            chk("busy_mid", 16'(busy), 16'h1);
            data_len  = ~len;
            msb_first = ~msb;
          end
          deser_en = 1'b1;
          edge_cnt = 6'(e);
          rx_in    = bits[b] ^ (b == flip_bit && e == 4);
        end
      end
    end
    if (!stopped) begin
      // Hold deser_en high through DONE with sample points passing: must not re-arm.
      for (int c = 0; c < 16; c++) begin
        @(negedge clk);
        edge_cnt = 6'(c % 8);
        rx_in    = c[2];
      end
      chk("busy_done", 16'(busy), 16'h0);
    end
    @(negedge clk);
    deser_en = 1'b0;
    rx_in    = 1'b1;
    repeat (3) @(negedge clk);
    chk("busy_idle", 16'(busy), 16'h0);
  endtask

  initial begin
    reset = 1'b1; deser_en = 1'b0; rx_in = 1'b1; prescale = 6'd8;
    edge_cnt = '0; data_len = 4'd8; msb_first = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_p_data", 16'(p_data), 16'h0);
    chk("reset_valid", 16'(data_valid), 16'h0);
    chk("reset_busy", 16'(busy), 16'h0);
    chk("reset_noise", 16'(noise_err), 16'h0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    exp_q.push_back(10'h0A5); frame(16'h00A5, 8, 4'd8, 1'b0, -1, -1, 1'b0);
    exp_q.push_back(10'h080); frame(16'h0001, 8, 4'd8, 1'b1, -1, -1, 1'b0);
    exp_q.push_back(10'h001); frame(16'h0001, 8, 4'd8, 1'b0, -1, -1, 1'b0);
    exp_q.push_back(10'h00B); frame(16'h000B, 5, 4'd5, 1'b0, -1, -1, 1'b0);
    exp_q.push_back(10'h01A); frame(16'h000B, 5, 4'd5, 1'b1, -1, -1, 1'b0);
    exp_q.push_back(10'h1FF); frame(16'h01FF, 9, 4'd12, 1'b0, -1, -1, 1'b0);
    exp_q.push_back(10'h01D); frame(16'h001D, 5, 4'd2, 1'b0, -1, -1, 1'b0);

    exp_q.push_back(10'h0A5); frame(16'h00A5, 8, 4'd8, 1'b0, -1, -1, 1'b0);
    frame(16'h00FF, 8, 4'd8, 1'b0, -1, 3, 1'b0);
    chk("abort_keeps_p_data", 16'(p_data), 16'h0A5);
    exp_q.push_back(10'h03C); frame(16'h003C, 8, 4'd8, 1'b0, -1, -1, 1'b0);

`ifdef UART_RX_MAJORITY_EN
    exp_q.push_back(10'h2A5);
`else
    exp_q.push_back(10'h0A4);
`endif
    frame(16'h00A5, 8, 4'd8, 1'b0, 0, -1, 1'b0);
    exp_q.push_back(10'h05A); frame(16'h005A, 8, 4'd8, 1'b0, -1, -1, 1'b0);

    frame(16'h00A5, 8, 4'd8, 1'b0, -1, 4, 1'b1);
    chk("post_reset_p_data", 16'(p_data), 16'h0);
    exp_q.push_back(10'h0A5); frame(16'h00A5, 8, 4'd8, 1'b0, -1, -1, 1'b0);

    repeat (4) @(negedge clk);
    chk("scoreboard_drained", 16'(exp_q.size()), 16'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
